// File: rtl/biu_prefetch_queue.sv
// Bus-interface fetch stage: reads code bytes from (CS<<4)+fetch_ptr into a 4-byte prefetch
// queue and presents them little-endian to decode, tracking the architectural IP of the head byte.
module biu_prefetch_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int ADDR_W      = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              CS,
    input  logic                     IP_load,
    input  logic [15:0]              IP_new,
    output logic [ADDR_W-1:0]        Direction,
    output logic                     mem_rd,
    input  logic                     mem_ack,
    input  logic [7:0]               Data_in,
    input  logic [2:0]               consume,
    output logic [8*QUEUE_DEPTH-1:0] Instruction,
    output logic [2:0]               Queue_count,
    output logic [15:0]              IP
);

    localparam int QW = 8 * QUEUE_DEPTH;

    typedef enum logic {
        IDLE,
        REQ
    } state_e;

    state_e            state_q, state_d;
    logic [QW-1:0]     queue_q, queue_d;
    logic [2:0]        count_q, count_d;
    logic [15:0]       ip_q, ip_d;
    logic [15:0]       fetch_ptr_q, fetch_ptr_d;
    logic [ADDR_W-1:0] direction_q, direction_d;
    logic              discard_q, discard_d;

    logic [2:0]        removed;
    logic [2:0]        count_after;
    logic [ADDR_W-1:0] fetch_addr;

    // Decode may ask for more than is queued; only what is present gets retired.
    assign removed     = (consume > count_q) ? count_q : consume;
    assign count_after = count_q - removed;
    assign fetch_addr  = ADDR_W'({CS, 4'h0}) + ADDR_W'(fetch_ptr_q);

    always_comb begin
        state_d     = state_q;
        queue_d     = queue_q;
        count_d     = count_q;
        ip_d        = ip_q;
        fetch_ptr_d = fetch_ptr_q;
        direction_d = direction_q;
        discard_d   = discard_q;

        if (IP_load) begin
            queue_d     = '0;
            count_d     = 3'd0;
            ip_d        = IP_new;
            fetch_ptr_d = IP_new;
            // A request already on the bus cannot be aborted, so its byte is marked stale.
            if (state_q == REQ) begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    discard_d = 1'b0;
                end else begin
                    discard_d = 1'b1;
                end
            end
        end else begin
            // Slots above the count are kept zero, so shifting and OR-ing in the tail is enough.
            queue_d = queue_q >> {removed, 3'b000};
            count_d = count_after;
            ip_d    = ip_q + 16'(removed);

            case (state_q)
                IDLE: begin
                    if (count_after < 3'(QUEUE_DEPTH)) begin
                        state_d     = REQ;
                        direction_d = fetch_addr;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        state_d   = IDLE;
                        discard_d = 1'b0;
                        if (!discard_q) begin
                            queue_d     = queue_d | (QW'(Data_in) << {count_after, 3'b000});
                            count_d     = count_after + 3'd1;
                            fetch_ptr_d = fetch_ptr_q + 16'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            queue_q     <= '0;
            count_q     <= 3'd0;
            ip_q        <= 16'h0000;
            fetch_ptr_q <= 16'h0000;
            direction_q <= '0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            queue_q     <= queue_d;
            count_q     <= count_d;
            ip_q        <= ip_d;
            fetch_ptr_q <= fetch_ptr_d;
            direction_q <= direction_d;
            discard_q   <= discard_d;
        end
    end

    always_comb begin
        Instruction = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (3'(i) < count_q) begin
                Instruction[i*8 +: 8] = queue_q[i*8 +: 8];
            end
        end
    end

    assign mem_rd      = (state_q == REQ);
    assign Direction   = direction_q;
    assign Queue_count = count_q;
    assign IP          = ip_q;

endmodule

// File: tb/tb_biu_prefetch_queue.sv
// Self-checking bench for biu_prefetch_queue: directed scenarios against fixed values, then
// randomized traffic against a byte-queue reference model of the fetch stage.
module tb_biu_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] csVal;
    logic        ipLoad;
    logic [15:0] ipNew;
    logic        ackVal;
    logic [7:0]  dataVal;
    logic [2:0]  consumeVal;

    logic [19:0] direction;
    logic        memRd;
    logic [31:0] instruction;
    logic [2:0]  queueCount;
    logic [15:0] ipOut;

    int checks = 0;
    int errors = 0;

    // Reference model: queued bytes, head offset, fetch offset, outstanding request.
    logic [7:0]  mQ[$];
    logic [15:0] mIp;
    logic [15:0] mFetch;
    logic [19:0] mDir;
    bit          mReq;
    bit          mDiscard;

    biu_prefetch_queue #(.QUEUE_DEPTH(4), .ADDR_W(20)) dut (
        .clk        (clk),
        .reset      (reset),
        .CS         (csVal),
        .IP_load    (ipLoad),
        .IP_new     (ipNew),
        .Direction  (direction),
        .mem_rd     (memRd),
        .mem_ack    (ackVal),
        .Data_in    (dataVal),
        .consume    (consumeVal),
        .Instruction(instruction),
        .Queue_count(queueCount),
        .IP         (ipOut)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mQ.delete();
        mIp      = 16'h0000;
        mFetch   = 16'h0000;
        mDir     = 20'h00000;
        mReq     = 1'b0;
        mDiscard = 1'b0;
    endtask

    task automatic modelEdge();
        int removed;
        removed = (int'(consumeVal) > mQ.size()) ? mQ.size() : int'(consumeVal);
        if (ipLoad) begin
            if (mReq && ackVal) begin
                mReq     = 1'b0;
                mDiscard = 1'b0;
            end else if (mReq) begin
                mDiscard = 1'b1;
            end
            mQ.delete();
            mIp    = ipNew;
            mFetch = ipNew;
        end else begin
            for (int k = 0; k < removed; k++) void'(mQ.pop_front());
            mIp = mIp + 16'(removed);
            if (mReq) begin
                if (ackVal) begin
                    if (!mDiscard) begin
                        mQ.push_back(dataVal);
                        mFetch = mFetch + 16'd1;
                    end
                    mDiscard = 1'b0;
                    mReq     = 1'b0;
                end
            end else if (mQ.size() < 4) begin
                mReq = 1'b1;
                mDir = {csVal, 4'h0} + {4'h0, mFetch};
            end
        end
    endtask

    function automatic logic [31:0] modelWord();
        logic [31:0] w = 32'h0;
        for (int i = 0; i < mQ.size(); i++) w[i*8 +: 8] = mQ[i];
        return w;
    endfunction

    // One clock: model follows the same edge, inputs return to idle just after it.
    task automatic tick();
        @(posedge clk);
        modelEdge();
        #1;
        ipLoad     = 1'b0;
        ackVal     = 1'b0;
        consumeVal = 3'd0;
    endtask

    task automatic test_reset();
        reset = 1'b0; csVal = 16'h0; ipLoad = 1'b0; ipNew = 16'h0;
        ackVal = 1'b0; dataVal = 8'h0; consumeVal = 3'd0;
        modelReset();
        #2;
        checks++; if (memRd !== 1'b0) begin errors++; $display("[TB] FAIL reset_mem_rd got %b want 0", memRd); end
        checks++; if (queueCount !== 3'd0) begin errors++; $display("[TB] FAIL reset_count got %0d want 0", queueCount); end
        checks++; if (direction !== 20'h0) begin errors++; $display("[TB] FAIL reset_direction got %h want 00000", direction); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("[TB] FAIL reset_instruction got %h want 00000000", instruction); end
        checks++; if (ipOut !== 16'h0) begin errors++; $display("[TB] FAIL reset_ip got %h want 0000", ipOut); end
    endtask

    task automatic test_fill();
        logic [7:0] fillBytes [4];
        fillBytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        @(posedge clk);
        #1;
        reset = 1'b1; csVal = 16'h1000; ipLoad = 1'b1; ipNew = 16'h0010;
        tick();
        checks++; if (ipOut !== 16'h0010) begin errors++; $display("[TB] FAIL fill_ip_load got %h want 0010", ipOut); end
        checks++; if (memRd !== 1'b0) begin errors++; $display("[TB] FAIL fill_no_req_on_load got %b want 0", memRd); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (memRd !== 1'b1) begin errors++; $display("[TB] FAIL fill_req%0d got %b want 1", i, memRd); end
            checks++; if (direction !== 20'h10010 + 20'(i)) begin errors++; $display("[TB] FAIL fill_addr%0d got %h want %h", i, direction, 20'h10010 + 20'(i)); end
            ackVal = 1'b1; dataVal = fillBytes[i];
            tick();
            checks++; if (memRd !== 1'b0) begin errors++; $display("[TB] FAIL fill_ack%0d got %b want 0", i, memRd); end
        end
        checks++; if (instruction !== 32'hDDCCBBAA) begin errors++; $display("[TB] FAIL fill_word got %h want DDCCBBAA", instruction); end
        checks++; if (queueCount !== 3'd4) begin errors++; $display("[TB] FAIL fill_count got %0d want 4", queueCount); end
        tick();
        tick();
        checks++; if (memRd !== 1'b0) begin errors++; $display("[TB] FAIL fill_full_idle got %b want 0", memRd); end
    endtask

    task automatic test_consume();
        consumeVal = 3'd2;
        tick();
        checks++; if (instruction !== 32'h0000DDCC) begin errors++; $display("[TB] FAIL consume_word got %h want 0000DDCC", instruction); end
        checks++; if (ipOut !== 16'h0012) begin errors++; $display("[TB] FAIL consume_ip got %h want 0012", ipOut); end
        checks++; if (queueCount !== 3'd2) begin errors++; $display("[TB] FAIL consume_count got %0d want 2", queueCount); end
        checks++; if (memRd !== 1'b1) begin errors++; $display("[TB] FAIL consume_req got %b want 1", memRd); end
        checks++; if (direction !== 20'h10014) begin errors++; $display("[TB] FAIL consume_addr got %h want 10014", direction); end
    endtask

    task automatic test_back_to_back();
        ackVal = 1'b1; dataVal = 8'h11;
        tick();
        checks++; if (queueCount !== 3'd3) begin errors++; $display("[TB] FAIL b2b_count_pre got %0d want 3", queueCount); end
        tick();
        checks++; if (direction !== 20'h10015) begin errors++; $display("[TB] FAIL b2b_addr got %h want 10015", direction); end
        ackVal = 1'b1; dataVal = 8'h22; consumeVal = 3'd1;
        tick();
        checks++; if (queueCount !== 3'd3) begin errors++; $display("[TB] FAIL b2b_count got %0d want 3", queueCount); end
        checks++; if (ipOut !== 16'h0013) begin errors++; $display("[TB] FAIL b2b_ip got %h want 0013", ipOut); end
        checks++; if (instruction !== 32'h002211DD) begin errors++; $display("[TB] FAIL b2b_word got %h want 002211DD", instruction); end
    endtask

    task automatic test_flush_inflight();
        tick();
        checks++; if (direction !== 20'h10016) begin errors++; $display("[TB] FAIL flush_pre_addr got %h want 10016", direction); end
        ipLoad = 1'b1; ipNew = 16'h0100;
        tick();
        checks++; if (queueCount !== 3'd0) begin errors++; $display("[TB] FAIL flush_count got %0d want 0", queueCount); end
        checks++; if (ipOut !== 16'h0100) begin errors++; $display("[TB] FAIL flush_ip got %h want 0100", ipOut); end
        checks++; if (memRd !== 1'b1) begin errors++; $display("[TB] FAIL flush_hold_req got %b want 1", memRd); end
        tick();
        checks++; if (direction !== 20'h10016) begin errors++; $display("[TB] FAIL flush_addr_stable got %h want 10016", direction); end
        ackVal = 1'b1; dataVal = 8'hEE;
        tick();
        checks++; if (queueCount !== 3'd0) begin errors++; $display("[TB] FAIL flush_drop_count got %0d want 0", queueCount); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("[TB] FAIL flush_drop_word got %h want 00000000", instruction); end
        tick();
        checks++; if (direction !== 20'h10100) begin errors++; $display("[TB] FAIL flush_restart_addr got %h want 10100", direction); end
        ackVal = 1'b1; dataVal = 8'h33;
        tick();
        checks++; if (instruction !== 32'h00000033) begin errors++; $display("[TB] FAIL flush_first_byte got %h want 00000033", instruction); end
    endtask

    task automatic test_wrap();
        csVal = 16'hFFFF; ipLoad = 1'b1; ipNew = 16'hFFFF;
        tick();
        tick();
        checks++; if (direction !== 20'h0FFEF) begin errors++; $display("[TB] FAIL wrap_addr got %h want 0FFEF", direction); end
        ackVal = 1'b1; dataVal = 8'h44;
        tick();
        consumeVal = 3'd1;
        tick();
        checks++; if (direction !== 20'hFFFF0) begin errors++; $display("[TB] FAIL wrap_fetch_ptr got %h want FFFF0", direction); end
        checks++; if (ipOut !== 16'h0000) begin errors++; $display("[TB] FAIL wrap_ip got %h want 0000", ipOut); end
        ackVal = 1'b1; dataVal = 8'h55;
        tick();
    endtask

    task automatic test_async_reset();
        tick();
        checks++; if (memRd !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre_req got %b want 1", memRd); end
        #2;
        reset = 1'b0;
        #1;
        modelReset();
        checks++; if (memRd !== 1'b0) begin errors++; $display("[TB] FAIL areset_mem_rd got %b want 0", memRd); end
        checks++; if (queueCount !== 3'd0) begin errors++; $display("[TB] FAIL areset_count got %0d want 0", queueCount); end
        checks++; if (direction !== 20'h0) begin errors++; $display("[TB] FAIL areset_direction got %h want 00000", direction); end
        checks++; if (instruction !== 32'h0) begin errors++; $display("[TB] FAIL areset_word got %h want 00000000", instruction); end
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_random();
        logic [31:0] expWord;
        for (int n = 0; n < 400; n++) begin
            ipLoad     = ($urandom_range(0, 15) == 0);
            ipNew      = 16'($urandom);
            consumeVal = 3'($urandom_range(0, 5));
            dataVal    = 8'($urandom);
            ackVal     = mReq && ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 31) == 0) csVal = 16'($urandom);
            tick();
            expWord = modelWord();
            checks++; if (memRd !== mReq) begin errors++; $display("[TB] FAIL rnd_mem_rd cyc %0d got %b want %b", n, memRd, mReq); end
            checks++; if (direction !== mDir) begin errors++; $display("[TB] FAIL rnd_direction cyc %0d got %h want %h", n, direction, mDir); end
            checks++; if (queueCount !== 3'(mQ.size())) begin errors++; $display("[TB] FAIL rnd_count cyc %0d got %0d want %0d", n, queueCount, mQ.size()); end
            checks++; if (ipOut !== mIp) begin errors++; $display("[TB] FAIL rnd_ip cyc %0d got %h want %h", n, ipOut, mIp); end
            checks++; if (instruction !== expWord) begin errors++; $display("[TB] FAIL rnd_word cyc %0d got %h want %h", n, instruction, expWord); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_consume();
        test_back_to_back();
        test_flush_inflight();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
